pipe_ctrl: RTL and testbench

//   Pipeline control unit that produces the stall vector and flush consumed by every

---
 rtl/pipe_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control: builds the per-stage stall vector, counts multi-cycle EX ops,
// detects load-use hazards and sequences (possibly deferred) branch redirects.
module pipe_ctrl #(
  parameter int unsigned MC_CYCLES = 4,
  parameter int unsigned PC_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_wait_i,
  input  logic            mem_wait_i,
  input  logic            ex_is_load_i,
  input  logic            ex_wreg_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic            id_rs1_read_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic            id_rs2_read_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic            ex_mc_start_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  output logic [5:0]      stall_o,
  output logic            flush_o,
  output logic [PC_W-1:0] new_pc_o,
  output logic            mc_done_o
);

  localparam int unsigned CNT_W = $clog2(MC_CYCLES);

  localparam logic S_IDLE    = 1'b0;
  localparam logic S_MC_BUSY = 1'b1;

  logic             r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_pend;
  logic [PC_W-1:0]  r_pend_pc;

  logic             w_lu;
  logic             w_mc_done;
  logic             w_mc_req;
  logic             w_ex_stall;
  logic             w_flush;
  logic [5:0]       w_stall;
  logic [PC_W-1:0]  w_new_pc;

  always_comb begin
    w_lu = ex_is_load_i && ex_wreg_i && (ex_rd_addr_i != 5'd0) &&
           ((id_rs1_read_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
            (id_rs2_read_i && (id_rs2_addr_i == ex_rd_addr_i)));

    w_mc_done = (r_state == S_MC_BUSY) && (r_count == CNT_W'(1)) && !mem_wait_i;
    w_mc_req  = ((r_state == S_IDLE) && ex_mc_start_i) ||
                ((r_state == S_MC_BUSY) && !w_mc_done);

    // EX stall is resolved before flush so that flush can mask load-use without a loop.
    w_ex_stall = mem_wait_i || w_mc_req;
    w_flush    = !w_ex_stall && (branch_taken_i || r_pend);

    if (!w_flush)            w_new_pc = '0;
    else if (branch_taken_i) w_new_pc = branch_target_i;
    else                     w_new_pc = r_pend_pc;

    if (mem_wait_i)              w_stall = 6'b011111;
    else if (w_mc_req)           w_stall = 6'b001111;
    else if (w_lu && !w_flush)   w_stall = 6'b000111;
    else if (if_wait_i)          w_stall = 6'b000011;
    else                         w_stall = 6'b000000;
  end

  always_comb begin
    stall_o   = rst ? w_stall   : '0;
    flush_o   = rst ? w_flush   : 1'b0;
    new_pc_o  = rst ? w_new_pc  : '0;
    mc_done_o = rst ? w_mc_done : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ex_mc_start_i) begin
            r_state <= S_MC_BUSY;
            r_count <= CNT_W'(MC_CYCLES - 1);
          end
        end
        default: begin
          if (!mem_wait_i) begin
            r_count <= r_count - CNT_W'(1);
            if (r_count == CNT_W'(1)) r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
    end else if (branch_taken_i && w_ex_stall) begin
      r_pend    <= 1'b1;
      r_pend_pc <= branch_target_i;
    end else if (w_flush) begin
      r_pend    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Cycle-by-cycle vector table for pipe_ctrl; expectations go through a scoreboard queue.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_wait_i, mem_wait_i, ex_is_load_i, ex_wreg_i;
  logic [4:0]  ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i;
  logic        id_rs1_read_i, id_rs2_read_i, ex_mc_start_i, branch_taken_i;
  logic [31:0] branch_target_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        mc_done_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MC_CYCLES(4), .PC_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_wait_i(if_wait_i), .mem_wait_i(mem_wait_i),
    .ex_is_load_i(ex_is_load_i), .ex_wreg_i(ex_wreg_i), .ex_rd_addr_i(ex_rd_addr_i),
    .id_rs1_read_i(id_rs1_read_i), .id_rs1_addr_i(id_rs1_addr_i),
    .id_rs2_read_i(id_rs2_read_i), .id_rs2_addr_i(id_rs2_addr_i),
    .ex_mc_start_i(ex_mc_start_i), .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o), .mc_done_o(mc_done_o)
  );

  typedef struct {
    string       nm;
    logic        ifw, memw, ld, wreg;
    logic [4:0]  rd;
    logic        r1;
    logic [4:0]  a1;
    logic        r2;
    logic [4:0]  a2;
    logic        mcs, br;
    logic [31:0] tgt;
    logic [5:0]  st;
    logic        fl;
    logic [31:0] npc;
    logic        done;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(string nm, logic ifw, logic memw, logic ld, logic wreg,
                              logic [4:0] rd, logic r1, logic [4:0] a1, logic r2,
                              logic [4:0] a2, logic mcs, logic br, logic [31:0] tgt,
                              logic [5:0] st, logic fl, logic [31:0] npc, logic done);
    vec_t v;
    v.nm = nm; v.ifw = ifw; v.memw = memw; v.ld = ld; v.wreg = wreg; v.rd = rd;
    v.r1 = r1; v.a1 = a1; v.r2 = r2; v.a2 = a2; v.mcs = mcs; v.br = br; v.tgt = tgt;
    v.st = st; v.fl = fl; v.npc = npc; v.done = done;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    if_wait_i = v.ifw; mem_wait_i = v.memw; ex_is_load_i = v.ld; ex_wreg_i = v.wreg;
    ex_rd_addr_i = v.rd; id_rs1_read_i = v.r1; id_rs1_addr_i = v.a1;
    id_rs2_read_i = v.r2; id_rs2_addr_i = v.a2; ex_mc_start_i = v.mcs;
    branch_taken_i = v.br; branch_target_i = v.tgt;
  endtask

  task automatic check_now();
    vec_t e;
    logic [31:0] got_pc, exp_pc;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty got=none required=entry");
      return;
    end
    e = exp_q.pop_front();
    got_pc = e.fl ? new_pc_o : 32'h0;
    exp_pc = e.fl ? e.npc    : 32'h0;
    total++;
    if (stall_o !== e.st || flush_o !== e.fl || mc_done_o !== e.done || got_pc !== exp_pc) begin
      bad++;
      $display("FAIL %s got stall=%b flush=%b pc=%h done=%b required stall=%b flush=%b pc=%h done=%b",
               e.nm, stall_o, flush_o, new_pc_o, mc_done_o, e.st, e.fl, e.npc, e.done);
    end
  endtask

  // Drive one cycle of inputs just after posedge, compare at negedge.
  task automatic apply(input vec_t v);
    drive(v);
    exp_q.push_back(v);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // name                 ifw memw ld wr rd   r1 a1   r2 a2  mcs br tgt        stall      fl npc        done
    vecs.push_back(mk("idle",         0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b000000, 0,32'h0,   0));
    vecs.push_back(mk("lu_rs2",       0,0, 1,1,5'd5, 0,5'd0, 1,5'd5, 0,0,32'h0,   6'b000111, 0,32'h0,   0));
    vecs.push_back(mk("lu_rd_x0",     0,0, 1,1,5'd0, 1,5'd0, 1,5'd0, 0,0,32'h0,   6'b000000, 0,32'h0,   0));
    vecs.push_back(mk("lu_no_read",   0,0, 1,1,5'd5, 0,5'd5, 0,5'd5, 0,0,32'h0,   6'b000000, 0,32'h0,   0));
    vecs.push_back(mk("lu_rs1",       0,0, 1,1,5'd7, 1,5'd7, 1,5'd3, 0,0,32'h0,   6'b000111, 0,32'h0,   0));
    vecs.push_back(mk("not_load",     0,0, 0,1,5'd7, 1,5'd7, 0,5'd0, 0,0,32'h0,   6'b000000, 0,32'h0,   0));
    vecs.push_back(mk("no_wreg",      0,0, 1,0,5'd7, 1,5'd7, 0,5'd0, 0,0,32'h0,   6'b000000, 0,32'h0,   0));
    vecs.push_back(mk("if_wait",      1,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b000011, 0,32'h0,   0));
    vecs.push_back(mk("lu_over_ifw",  1,0, 1,1,5'd9, 1,5'd9, 0,5'd0, 0,0,32'h0,   6'b000111, 0,32'h0,   0));
    vecs.push_back(mk("mem_wait",     1,1, 1,1,5'd9, 1,5'd9, 0,5'd0, 0,0,32'h0,   6'b011111, 0,32'h0,   0));
    vecs.push_back(mk("br_direct",    0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,1,32'h40,  6'b000000, 1,32'h40,  0));
    vecs.push_back(mk("br_lu_ifw",    1,0, 1,1,5'd4, 1,5'd4, 0,5'd0, 0,1,32'h80,  6'b000011, 1,32'h80,  0));
    vecs.push_back(mk("br_lu",        0,0, 1,1,5'd4, 0,5'd0, 1,5'd4, 0,1,32'hC0,  6'b000000, 1,32'hC0,  0));
    vecs.push_back(mk("mc_start",     0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 1,0,32'h0,   6'b001111, 0,32'h0,   0));
    vecs.push_back(mk("mc_c3_restart",0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 1,0,32'h0,   6'b001111, 0,32'h0,   0));
    vecs.push_back(mk("mc_c2",        0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b001111, 0,32'h0,   0));
    vecs.push_back(mk("mc_done",      0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b000000, 0,32'h0,   1));
    vecs.push_back(mk("mc_after",     0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b000000, 0,32'h0,   0));
    vecs.push_back(mk("mcw_start",    0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 1,0,32'h0,   6'b001111, 0,32'h0,   0));
    vecs.push_back(mk("mcw_c3",       0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b001111, 0,32'h0,   0));
    vecs.push_back(mk("mcw_hold1",    0,1, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b011111, 0,32'h0,   0));
    vecs.push_back(mk("mcw_hold2",    0,1, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b011111, 0,32'h0,   0));
    vecs.push_back(mk("mcw_c2",       0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b001111, 0,32'h0,   0));
    vecs.push_back(mk("mcw_done",     0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b000000, 0,32'h0,   1));
    vecs.push_back(mk("pend_br",      0,1, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,1,32'h100, 6'b011111, 0,32'h0,   0));
    vecs.push_back(mk("pend_wait2",   0,1, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b011111, 0,32'h0,   0));
    vecs.push_back(mk("pend_wait3",   0,1, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b011111, 0,32'h0,   0));
    vecs.push_back(mk("pend_flush",   0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b000000, 1,32'h100, 0));
    vecs.push_back(mk("pend_clear",   0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b000000, 0,32'h0,   0));
    vecs.push_back(mk("mc_br_start",  0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 1,1,32'h200, 6'b001111, 0,32'h0,   0));
    vecs.push_back(mk("mc_br_newer",  0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,1,32'h300, 6'b001111, 0,32'h0,   0));
    vecs.push_back(mk("mc_br_c2",     0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b001111, 0,32'h0,   0));
    vecs.push_back(mk("mc_br_done",   0,0, 1,1,5'd6, 1,5'd6, 0,5'd0, 0,0,32'h0,   6'b000000, 1,32'h300, 1));
    vecs.push_back(mk("mc_br_after",  0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b000000, 0,32'h0,   0));
    vecs.push_back(mk("pend2_set",    0,1, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,1,32'h400, 6'b011111, 0,32'h0,   0));
    vecs.push_back(mk("pend2_young",  0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,1,32'h500, 6'b000000, 1,32'h500, 0));
    vecs.push_back(mk("pend2_after",  0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0,   6'b000000, 0,32'h0,   0));

    // Reset held with active inputs: every output forced low.
    rst = 1'b0;
    drive(mk("rst_hold", 1,1, 1,1,5'd5, 1,5'd5, 1,5'd5, 1,1,32'hDEAD, 6'b000000, 0,32'h0, 0));
    exp_q.push_back(mk("rst_hold", 1,1, 1,1,5'd5, 1,5'd5, 1,5'd5, 1,1,32'hDEAD, 6'b000000, 0,32'h0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_now();
    drive(vecs[0]);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset in the middle of a multi-cycle op with a pending redirect.
    apply(mk("rmid_start", 0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 1,1,32'h600, 6'b001111, 0,32'h0, 0));
    rst = 1'b0;
    drive(mk("rmid_hold", 1,1, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,1,32'h700, 6'b000000, 0,32'h0, 0));
    exp_q.push_back(mk("rmid_hold", 1,1, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,1,32'h700, 6'b000000, 0,32'h0, 0));
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply(mk("rmid_release", 0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0, 6'b000000, 0,32'h0, 0));
    apply(mk("rmid_idle",    0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,0,32'h0, 6'b000000, 0,32'h0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1);
  end

endmodule
